axis_magic_gate: RTL and testbench

//  Byte-stream gate for the UART command path: discards all input until a parametrised magic sequence is seen,

---
 rtl/magic_gate_pkg.sv | 10 +
 rtl/magic_matcher.sv | 29 ++
 rtl/axis_magic_gate.sv | 86 ++++++++
 tb/tb_axis_magic_gate.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/magic_gate_pkg.sv
// magic_gate_pkg: shared FSM states and magic-sequence byte lookup for axis_magic_gate.
package magic_gate_pkg;
  typedef enum logic [1:0] {GATE_LOCKED, GATE_UNLOCKED, GATE_DRAIN} gate_state_t;
  localparam int MAGIC_MAX = 32;
  localparam int MW = MAGIC_MAX * 8;
  // magic is left-aligned so byte 0 of the string sits in the top byte
  function automatic logic [7:0] magic_byte(input logic [MW-1:0] magic, input int unsigned idx);
    return magic[(MAGIC_MAX - 1 - idx) * 8 +: 8];
  endfunction
endpackage

// File: rtl/magic_matcher.sv
// magic_matcher: tracks progress through the magic sequence; match_done pulses on the accepted final byte.
module magic_matcher
  import magic_gate_pkg::*;
#(
  parameter int MAGIC_BYTES = 15,
  parameter logic [MAGIC_BYTES*8-1:0] MAGIC = "#!manilamagic!#",
  localparam int CW = $clog2(MAGIC_BYTES + 1)
) (
  input  logic          clk,
  input  logic          sresetn,
  input  logic          clear,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic [CW-1:0] match_cnt,
  output logic          match_done
);
  localparam logic [MW-1:0] MAGIC_L = MW'(MAGIC) << ((MAGIC_MAX - MAGIC_BYTES) * 8);
  logic w_hit, w_first, w_last;
  assign w_hit = byte_data == magic_byte(MAGIC_L, int'(match_cnt));
  assign w_first = byte_data == magic_byte(MAGIC_L, 0);
  assign w_last = match_cnt == CW'(MAGIC_BYTES - 1);
  assign match_done = byte_valid && !clear && w_hit && w_last;
  // a mismatching byte may itself start a fresh attempt
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) match_cnt <= '0;
    else if (clear) match_cnt <= '0;
    else if (byte_valid) match_cnt <= w_hit ? (w_last ? '0 : match_cnt + CW'(1)) : CW'(w_first);
  end
endmodule

// File: rtl/axis_magic_gate.sv
// axis_magic_gate: drops input until the magic sequence is seen, then forwards bytes via a 1-deep register.
// Optional idle auto-relock enabled by defining MAGIC_GATE_TIMEOUT_EN.
module axis_magic_gate
  import magic_gate_pkg::*;
#(
  parameter int MAGIC_BYTES = 15,
  parameter logic [MAGIC_BYTES*8-1:0] MAGIC = "#!manilamagic!#",
`ifdef MAGIC_GATE_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 50_000_000,
`endif
  localparam int CW = $clog2(MAGIC_BYTES + 1)
) (
  input  logic          clk,
  input  logic          sresetn,
  output logic          s_axis_tready,
  input  logic          s_axis_tvalid,
  input  logic [7:0]    s_axis_tdata,
  input  logic          m_axis_tready,
  output logic          m_axis_tvalid,
  output logic [7:0]    m_axis_tdata,
  input  logic          relock,
  output logic          unlocked,
  output logic [CW-1:0] match_cnt
);
  gate_state_t r_state;
  logic r_m_tvalid, r_unlocked;
  logic [7:0] r_m_tdata;
  logic w_locked, w_unl, w_s_hs, w_m_hs, w_load, w_done, w_timeout, w_relock;
  assign w_locked = r_state == GATE_LOCKED;
  assign w_unl = r_state == GATE_UNLOCKED;
  assign s_axis_tready = w_locked || (w_unl && (!r_m_tvalid || m_axis_tready));
  assign w_s_hs = s_axis_tvalid && s_axis_tready;
  assign w_m_hs = r_m_tvalid && m_axis_tready;
  assign w_load = w_unl && w_s_hs;
  assign w_relock = relock || w_timeout;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata = r_m_tdata;
  assign unlocked = r_unlocked;
`ifdef MAGIC_GATE_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] r_idle;
  // fires on the idle cycle that brings the count to TIMEOUT_CYCLES
  assign w_timeout = w_unl && !w_s_hs && r_idle == IW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) r_idle <= '0;
    else r_idle <= (w_unl && !w_s_hs && !w_timeout) ? r_idle + IW'(1) : '0;
  end
`else
  assign w_timeout = 1'b0;
`endif
  magic_matcher #(.MAGIC_BYTES(MAGIC_BYTES), .MAGIC(MAGIC)) u_matcher (
    .clk        (clk),
    .sresetn    (sresetn),
    .clear      (!w_locked || relock),
    .byte_valid (w_locked && s_axis_tvalid),
    .byte_data  (s_axis_tdata),
    .match_cnt  (match_cnt),
    .match_done (w_done)
  );
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      r_state <= GATE_LOCKED;
      r_m_tvalid <= 1'b0;
      r_m_tdata <= '0;
      r_unlocked <= 1'b0;
    end else begin
      if (w_load) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata <= s_axis_tdata;
      end else if (w_m_hs) r_m_tvalid <= 1'b0;
      case (r_state)
        GATE_LOCKED: if (w_done) begin
          r_state <= GATE_UNLOCKED;
          r_unlocked <= 1'b1;
        end
        // a byte still held (or just loaded) must drain before locking
        GATE_UNLOCKED: if (w_relock) begin
          r_state <= (w_load || (r_m_tvalid && !m_axis_tready)) ? GATE_DRAIN : GATE_LOCKED;
          r_unlocked <= 1'b0;
        end
        GATE_DRAIN: if (w_m_hs) r_state <= GATE_LOCKED;
        default: r_state <= GATE_LOCKED;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_magic_gate.sv
// tb_axis_magic_gate: table-driven vectors plus directed multi-cycle sequences for axis_magic_gate.
module tb_axis_magic_gate;
  logic clk = 1'b0, sresetn = 1'b0;
  logic s_tready, s_tvalid = 1'b0, m_tready = 1'b0, m_tvalid, rl = 1'b0, unl;
  logic [7:0] s_tdata = '0, m_tdata;
  logic [3:0] cnt;
  int checks = 0, failures = 0;
  string mg = "#!manilamagic!#";
  logic [7:0] mon[$];
  typedef struct {
    logic v; logic [7:0] d; logic rl; logic mr;
    logic [3:0] cnt; logic unl; logic mv; logic [7:0] md; logic str;
  } vec_t;
  vec_t vq[$];

  always #5 clk = ~clk;

`ifdef MAGIC_GATE_TIMEOUT_EN
  axis_magic_gate #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .sresetn(sresetn),
    .s_axis_tready(s_tready), .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata),
    .m_axis_tready(m_tready), .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata),
    .relock(rl), .unlocked(unl), .match_cnt(cnt)
  );
`else
  axis_magic_gate dut (
    .clk(clk), .sresetn(sresetn),
    .s_axis_tready(s_tready), .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata),
    .m_axis_tready(m_tready), .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata),
    .relock(rl), .unlocked(unl), .match_cnt(cnt)
  );
`endif

  always @(posedge clk) if (m_tvalid && m_tready) mon.push_back(m_tdata);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic v, input logic [7:0] d, input logic r, input logic mr,
                              input logic [3:0] c, input logic u, input logic mv, input logic [7:0] md,
                              input logic str);
    vq.push_back('{v, d, r, mr, c, u, mv, md, str});
  endfunction

  task automatic unlock();
    s_tvalid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      s_tdata = mg[i];
      tick();
    end
    s_tvalid = 1'b0;
    chk("unlock_seq", 8'(unl), 8'd1);
  endtask

  task automatic chk_mon(input string nm, input logic [7:0] exp[$]);
    chk({nm, "_count"}, 8'(mon.size()), 8'(exp.size()));
    for (int i = 0; i < exp.size() && i < mon.size(); i++) chk(nm, mon[i], exp[i]);
    mon.delete();
  endtask

  initial begin
    #2;
    chk("rst_cnt", 8'(cnt), 8'd0);
    chk("rst_unl", 8'(unl), 8'd0);
    chk("rst_mvalid", 8'(m_tvalid), 8'd0);
    chk("rst_mdata", m_tdata, 8'h00);
    tick();
    sresetn = 1'b1;
    m_tready = 1'b1;
    mon.delete();
    for (int i = 0; i < 6; i++) add(1, mg[i], 0, 1, 4'(i + 1), 0, 0, 0, 1);
    add(1, "x", 0, 1, 0, 0, 0, 0, 1);
    add(1, "#", 0, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) add(1, mg[i], 0, 1, (i == 14) ? 4'd0 : 4'(i + 1), i == 14, 0, 0, 1);
    add(1, 8'h55, 0, 1, 0, 1, 1, 8'h55, 1);
    add(0, 8'h00, 0, 1, 0, 1, 0, 0, 1);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0, 1);
    add(1, 8'h55, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(1, mg[i], 0, 1, 4'(i + 1), 0, 0, 0, 1);
    add(1, "a", 1, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 14; i++) add(1, mg[i], 0, 1, 4'(i + 1), 0, 0, 0, 1);
    add(1, "#", 1, 1, 0, 0, 0, 0, 1);
    add(1, "#", 0, 1, 1, 0, 0, 0, 1);
    foreach (vq[k]) begin
      s_tvalid = vq[k].v; s_tdata = vq[k].d; rl = vq[k].rl; m_tready = vq[k].mr;
      tick();
      chk($sformatf("vec%0d_cnt", k), 8'(cnt), 8'(vq[k].cnt));
      chk($sformatf("vec%0d_unl", k), 8'(unl), 8'(vq[k].unl));
      chk($sformatf("vec%0d_mvalid", k), 8'(m_tvalid), 8'(vq[k].mv));
      chk($sformatf("vec%0d_str", k), 8'(s_tready), 8'(vq[k].str));
      if (vq[k].mv) chk($sformatf("vec%0d_mdata", k), m_tdata, vq[k].md);
    end
    s_tvalid = 1'b0; rl = 1'b0;
    chk_mon("fwd_only_55", '{8'h55});
    unlock();
    m_tready = 1'b0;
    s_tvalid = 1'b1; s_tdata = 8'hA1;
    tick();
    chk("bp_mdata0", m_tdata, 8'hA1);
    chk("bp_str0", 8'(s_tready), 8'd0);
    s_tdata = 8'hA2;
    tick();
    tick();
    chk("bp_mdata_hold", m_tdata, 8'hA1);
    chk("bp_mvalid_hold", 8'(m_tvalid), 8'd1);
    m_tready = 1'b1;
    tick();
    s_tvalid = 1'b0;
    chk("bp_mdata1", m_tdata, 8'hA2);
    tick();
    chk("bp_mvalid_end", 8'(m_tvalid), 8'd0);
    chk_mon("bp_order", '{8'hA1, 8'hA2});
    m_tready = 1'b0;
    s_tvalid = 1'b1; s_tdata = 8'h3C;
    tick();
    s_tvalid = 1'b0; rl = 1'b1;
    tick();
    rl = 1'b0;
    chk("drain_unl", 8'(unl), 8'd0);
    chk("drain_str", 8'(s_tready), 8'd0);
    chk("drain_mdata", m_tdata, 8'h3C);
    rl = 1'b1;
    tick();
    rl = 1'b0;
    chk("drain_relock_ign", 8'(m_tvalid), 8'd1);
    chk("drain_str2", 8'(s_tready), 8'd0);
    m_tready = 1'b1;
    tick();
    chk("drain_done_mvalid", 8'(m_tvalid), 8'd0);
    chk("drain_done_str", 8'(s_tready), 8'd1);
    chk_mon("drain_out", '{8'h3C});
    unlock();
    s_tvalid = 1'b1; s_tdata = 8'h77; rl = 1'b1;
    tick();
    s_tvalid = 1'b0; rl = 1'b0;
    chk("rlhs_unl", 8'(unl), 8'd0);
    chk("rlhs_mdata", m_tdata, 8'h77);
    chk("rlhs_str", 8'(s_tready), 8'd0);
    tick();
    chk("rlhs_locked_str", 8'(s_tready), 8'd1);
    chk_mon("rlhs_out", '{8'h77});
    unlock();
    m_tready = 1'b0;
    s_tvalid = 1'b1; s_tdata = 8'h99;
    tick();
    #3 sresetn = 1'b0;
    #1;
    chk("arst_mvalid", 8'(m_tvalid), 8'd0);
    chk("arst_unl", 8'(unl), 8'd0);
    chk("arst_cnt", 8'(cnt), 8'd0);
    s_tvalid = 1'b0;
    tick();
    sresetn = 1'b1;
    s_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_tdata = mg[i];
      tick();
    end
    s_tvalid = 1'b0;
    chk("arst_pre_cnt", 8'(cnt), 8'd3);
    #3 sresetn = 1'b0;
    #1;
    chk("arst_cnt2", 8'(cnt), 8'd0);
    tick();
    sresetn = 1'b1;
    mon.delete();
`ifdef MAGIC_GATE_TIMEOUT_EN
    unlock();
    m_tready = 1'b1;
    repeat (99) tick();
    chk("to_99", 8'(unl), 8'd1);
    s_tvalid = 1'b1; s_tdata = 8'h5A;
    tick();
    s_tvalid = 1'b0;
    repeat (99) tick();
    chk("to_restart", 8'(unl), 8'd1);
    tick();
    chk("to_100", 8'(unl), 8'd0);
    chk_mon("to_out", '{8'h5A});
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
